// File: rtl/packet_sender_ece496.sv
// -----------------------------------------------------------------------------
// packet_sender_ece496
//
// Frames one packet on the shared UART transmitter each time the stream
// arbiter grants a stream. A packet is a header byte {HEADER_TAG, stream},
// PACKET_BYTES payload bytes popped from the granted FIFO, and a trailing XOR
// checksum of the payload. Completion is signalled with a one-cycle
// packet_sent pulse, which the arbiter uses to rotate or hold its grant.
//
// Parameters
//   PACKET_BYTES  payload bytes per packet, 1..255
//   HEADER_TAG    upper 5 bits of the header byte
//
// Ports
//   clock         system clock, all state changes on the rising edge
//   resetn        synchronous active-low reset
//   select_ready  arbiter grant valid, only looked at while idle
//   mux_select    granted stream index, captured when the packet starts
//   fifo_data     read data of the granted FIFO, valid one cycle after rd_en
//   fifo_empty    empty flag of the granted FIFO
//   uart_busy     UART transmitter busy, rises the cycle after uart_start
//   fifo_rd_en    one-hot read strobe, one pulse per payload byte
//   uart_start    one-cycle load strobe for the UART
//   uart_data     registered byte presented to the UART
//   packet_sent   one-cycle pulse once the checksum byte has gone out
//   sender_busy   high whenever a packet is in progress
// -----------------------------------------------------------------------------
module packet_sender_ece496 #(
    parameter logic [7:0] PACKET_BYTES = 8'd8,
    parameter logic [4:0] HEADER_TAG   = 5'b10100
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       select_ready,
    input  logic [2:0] mux_select,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    input  logic       uart_busy,
    output logic [7:0] fifo_rd_en,
    output logic       uart_start,
    output logic [7:0] uart_data,
    output logic       packet_sent,
    output logic       sender_busy
);

    // Send states (HDR/PAY/TRL) issue a UART start; each has a matching
    // wait state that holds until the UART finishes that byte.
    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_HDR_W,
        S_RD,
        S_LD,
        S_PAY,
        S_PAY_W,
        S_TRL,
        S_TRL_W,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] sel_q;      // stream owning the current packet
    logic [7:0] byte_cnt;   // payload bytes loaded so far
    logic [7:0] csum;       // running XOR of the payload

    // The checksum goes out once the last payload byte has finished.
    logic payload_done;
    assign payload_done = (byte_cnt >= PACKET_BYTES);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers: stream select, byte counter, checksum, UART byte
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sel_q     <= 3'd0;
            byte_cnt  <= 8'd0;
            csum      <= 8'd0;
            uart_data <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (select_ready) begin
                        sel_q     <= mux_select;
                        csum      <= 8'd0;
                        byte_cnt  <= 8'd0;
                        uart_data <= {HEADER_TAG, mux_select};
                    end
                end
                S_LD: begin
                    // fifo_data is the word popped by the rd_en pulse in RD.
                    uart_data <= fifo_data;
                    csum      <= csum ^ fifo_data;
                    byte_cnt  <= byte_cnt + 8'd1;
                end
                S_PAY_W: begin
                    // Load the trailer on the same edge that moves to TRL.
                    if (!uart_busy && payload_done) begin
                        uart_data <= csum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default before the case so
    // no path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        uart_start  = 1'b0;
        fifo_rd_en  = 8'd0;
        packet_sent = 1'b0;

        case (state)
            S_IDLE: begin
                if (select_ready) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (!uart_busy) begin
                    uart_start = 1'b1;
                    state_next = S_HDR_W;
                end
            end
            S_HDR_W: begin
                if (!uart_busy) begin
                    state_next = S_RD;
                end
            end
            S_RD: begin
                // Underflow guard: wait, without strobing, for data to arrive.
                if (!fifo_empty) begin
                    fifo_rd_en[sel_q] = 1'b1;
                    state_next        = S_LD;
                end
            end
            S_LD: begin
                state_next = S_PAY;
            end
            S_PAY: begin
                if (!uart_busy) begin
                    uart_start = 1'b1;
                    state_next = S_PAY_W;
                end
            end
            S_PAY_W: begin
                if (!uart_busy) begin
                    state_next = payload_done ? S_TRL : S_RD;
                end
            end
            S_TRL: begin
                if (!uart_busy) begin
                    uart_start = 1'b1;
                    state_next = S_TRL_W;
                end
            end
            S_TRL_W: begin
                if (!uart_busy) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                packet_sent = 1'b1;
                state_next  = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign sender_busy = (state != S_IDLE);

endmodule
